trap_ctrl: RTL and testbench
============================

# trap_ctrl

Parametrised trap controller for the main pipeline, next to the CSR unit. Registers per-stage PCs with valid bits, exception reports from the cushion stage and N masked interrupt lines. Arbitrates exception over interrupt and computes the direct or vectored handler address. Issues the trap to the CSR unit through a held request/acknowledge handshake, then enforces a hold-off window while the pipeline drains.

## Interface
- NUM_STAGES, 6: number of pipeline PCs tracked; index NUM_STAGES-1 is the oldest stage (cushion), index 0 is fetch.
- NUM_INT, 16: number of interrupt lines; legal range 1..32.
- CODE_W, 5: width of the cause code; must satisfy NUM_INT ≤ 2^CODE_W.
- HOLDOFF, 3: cycles after acknowledge during which no new trap is taken; 0 is legal.
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous clear of the captured inputs.
- MMU_WAIT  in  1  stall; freezes the capture registers.
- STAGE_PC  in  32*NUM_STAGES  stage PCs, concatenated; stage i is at [32i+31:32i].
- STAGE_VALID  in  NUM_STAGES  stage i holds a real instruction.
- EXC_EN  in  1  cushion-stage exception.
- EXC_CODE  in  CODE_W  exception cause.
- INT_PEND  in  NUM_INT  level interrupt pending lines.
- INT_MASK  in  NUM_INT  per-line enable (mie).
- INT_GLOBAL_EN  in  1  global interrupt enable (mstatus.MIE).
- TRAP_VEC_MODE  in  2  0 = direct, 1 = vectored, 2/3 = treated as direct.
- TRAP_VEC_BASE  in  32  handler base; bits [1:0] are ignored (forced to 0).
- TRAP_ACK  in  1  CSR unit has consumed the trap.
- TRAP_EN  out  1  trap request; held until acknowledged.
- TRAP_PC  out  32  mepc value.
- TRAP_CODE  out  32  mcause value; bit31 = interrupt, cause in [CODE_W-1:0], other bits 0.
- TRAP_JMP_TO  out  32  handler address.
- TRAP_BUSY  out  1  FSM is not IDLE.

## Operation
- Capture registers hold every input except TRAP_ACK.
  - RST_N low or FLUSH: all cleared.
  - MMU_WAIT: hold.
  - Otherwise: load. RST_N takes precedence over FLUSH, which takes precedence over MMU_WAIT.
- Eligible interrupt vector = pend & mask, gated by global_en (all from captured values).
- Selected interrupt = highest set index of the eligible vector.
- trap_req = exc_en || (eligible vector ≠ 0). Exception wins over interrupt.
- PC select: captured PC of the highest-index valid stage. If no stage is valid, 0.
- Cause:
  - Exception: {1'b0, zero-fill, exc_code}.
  - Interrupt: {1'b1, zero-fill, index}.
- Handler address:
  - base & ~3, except when the mode is 1 and the trap is an interrupt.
  - In that case: (base & ~3) + (index << 2), mod 2^32.
  - Exceptions are never vectored.
- FSM states:
  - IDLE: if trap_req, latch PC, cause and handler address into the output registers, set TRAP_EN, go to ISSUE.
  - ISSUE: outputs frozen, TRAP_EN = 1. On TRAP_ACK, clear TRAP_EN. Then go to HOLDOFF, or go to IDLE if HOLDOFF = 0.
  - HOLDOFF: a down-counter (width clog2(HOLDOFF+1)) is loaded with HOLDOFF on entry. Exit to IDLE when it reaches 1 → HOLDOFF cycles spent in the state. trap_req is ignored.
- FLUSH and MMU_WAIT do not alter FSM state or the output registers. The CSR unit's own flush cannot cancel an issued trap.

## Timing
- Reset values: TRAP_EN = 0, TRAP_PC = 0, TRAP_CODE = 0, TRAP_JMP_TO = 0, TRAP_BUSY = 0, FSM = IDLE, capture registers = 0.
- Latency: an input sampled at edge E raises TRAP_EN after edge E+1. All outputs are registered.
- TRAP_ACK is sampled only in ISSUE. An ACK in the same cycle that TRAP_EN first rises is valid. TRAP_EN falls after that edge.
- An ACK in IDLE or HOLDOFF is ignored.
- Minimum spacing between two TRAP_EN rising edges: 2 + HOLDOFF cycles.
- Interrupt lines are level-sensitive. A line deasserted before capture is lost. Once a trap is latched into ISSUE, it is kept regardless of later input changes.
- Asynchronous reset mid-ISSUE drops the trap immediately: outputs go to reset values with no ACK required.

## Structure
- Shared package trap_pkg holds:
  - FSM state encoding (IDLE, ISSUE, HOLDOFF).
  - Vector-mode constants (VEC_DIRECT = 2'd0, VEC_VECTORED = 2'd1).
  - Bit position of the mcause interrupt flag (31).
- One sub-module: trap_prio_enc, a parametrised highest-index priority encoder.
  - Inputs: a NUM_INT-bit vector.
  - Outputs: an any-set flag and a clog2(NUM_INT)-bit index.
  - Also reused for PC-stage selection with width NUM_STAGES.

## Test plan
- Stage selection: STAGE_VALID = 6'b001101, stage-3 PC = 0x0000_1040, EXC_EN = 1, EXC_CODE = 2, TRAP_VEC_BASE = 0x8000_0001, mode 1 → TRAP_EN two edges later; TRAP_PC = 0x0000_1040; TRAP_CODE = 0x0000_0002; TRAP_JMP_TO = 0x8000_0000.
- Vectored interrupt: INT_PEND = 0x0880, INT_MASK = 0xFFFF, global enable = 1, mode 1, base 0x8000_0000 → TRAP_CODE = 0x8000_000B; TRAP_JMP_TO = 0x8000_002C.
- Exception beats interrupt: EXC_EN = 1 (code 5) with INT_PEND = 0x0008 enabled in the same cycle → TRAP_CODE = 0x0000_0005. After the interrupt stays asserted through hold-off, a second trap follows with TRAP_CODE = 0x8000_0003.
- Masking: INT_PEND = 0x0080 with INT_MASK = 0x0000, or with global enable = 0 → TRAP_EN stays 0 for 20 cycles.
- Handshake and stall:
  - Hold TRAP_ACK low for 5 cycles while toggling MMU_WAIT, FLUSH and INT_PEND → TRAP_EN and all outputs stay stable.
  - ACK → TRAP_EN falls next edge; TRAP_BUSY stays high exactly HOLDOFF = 3 further cycles.
- Reset: assert RST_N low asynchronously mid-ISSUE → all outputs are 0 before the next CLK edge. After release, no trap is issued until new inputs are captured.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared definitions for the trap controller: FSM encoding, trap-vector modes
// and the mcause layout.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } trap_state_t;

  localparam logic [1:0] VEC_DIRECT   = 2'd0;
  localparam logic [1:0] VEC_VECTORED = 2'd1;

  localparam int MCAUSE_INT_BIT = 31;

endpackage

// File: rtl/trap_prio_enc.sv
// Highest-index-wins priority encoder, purely combinational.
// No handshake: any = |vec, and idx is 0 when nothing is set.
module trap_prio_enc #(
  parameter int WIDTH = 16,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: captures pipeline/interrupt state, picks exception over interrupt,
// issues one trap to the CSR unit (held until TRAP_ACK) then holds off HOLDOFF cycles.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int NUM_STAGES = 6,
  parameter int NUM_INT    = 16,
  parameter int CODE_W     = 5,
  parameter int HOLDOFF    = 3
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    FLUSH,
  input  logic                    MMU_WAIT,
  input  logic [32*NUM_STAGES-1:0] STAGE_PC,
  input  logic [NUM_STAGES-1:0]   STAGE_VALID,
  input  logic                    EXC_EN,
  input  logic [CODE_W-1:0]       EXC_CODE,
  input  logic [NUM_INT-1:0]      INT_PEND,
  input  logic [NUM_INT-1:0]      INT_MASK,
  input  logic                    INT_GLOBAL_EN,
  input  logic [1:0]              TRAP_VEC_MODE,
  input  logic [31:0]             TRAP_VEC_BASE,
  input  logic                    TRAP_ACK,
  output logic                    TRAP_EN,
  output logic [31:0]             TRAP_PC,
  output logic [31:0]             TRAP_CODE,
  output logic [31:0]             TRAP_JMP_TO,
  output logic                    TRAP_BUSY
);

  localparam int IDX_W = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;
  localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int CNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [32*NUM_STAGES-1:0] cap_pc;
  logic [NUM_STAGES-1:0]    cap_valid;
  logic                     cap_exc;
  logic [CODE_W-1:0]        cap_code;
  logic [NUM_INT-1:0]       cap_pend;
  logic [NUM_INT-1:0]       cap_mask;
  logic                     cap_ge;
  logic [1:0]               cap_mode;
  logic [31:0]              cap_base;

  // Reset beats FLUSH beats MMU_WAIT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cap_pc    <= '0;
      cap_valid <= '0;
      cap_exc   <= 1'b0;
      cap_code  <= '0;
      cap_pend  <= '0;
      cap_mask  <= '0;
      cap_ge    <= 1'b0;
      cap_mode  <= '0;
      cap_base  <= '0;
    end else if (FLUSH) begin
      cap_pc    <= '0;
      cap_valid <= '0;
      cap_exc   <= 1'b0;
      cap_code  <= '0;
      cap_pend  <= '0;
      cap_mask  <= '0;
      cap_ge    <= 1'b0;
      cap_mode  <= '0;
      cap_base  <= '0;
    end else if (!MMU_WAIT) begin
      cap_pc    <= STAGE_PC;
      cap_valid <= STAGE_VALID;
      cap_exc   <= EXC_EN;
      cap_code  <= EXC_CODE;
      cap_pend  <= INT_PEND;
      cap_mask  <= INT_MASK;
      cap_ge    <= INT_GLOBAL_EN;
      cap_mode  <= TRAP_VEC_MODE;
      cap_base  <= TRAP_VEC_BASE;
    end
  end

  logic [NUM_INT-1:0] int_elig;
  logic               int_any;
  logic [IDX_W-1:0]   int_idx;
  logic               stg_any;
  logic [STG_W-1:0]   stg_idx;

  assign int_elig = cap_ge ? (cap_pend & cap_mask) : '0;

  trap_prio_enc #(.WIDTH(NUM_INT), .IDX_W(IDX_W)) u_int_enc (
    .vec (int_elig),
    .any (int_any),
    .idx (int_idx)
  );

  // Same encoder picks the oldest valid stage.
  trap_prio_enc #(.WIDTH(NUM_STAGES), .IDX_W(STG_W)) u_stg_enc (
    .vec (cap_valid),
    .any (stg_any),
    .idx (stg_idx)
  );

  logic        trap_req;
  logic [31:0] sel_pc;
  logic [31:0] nxt_code;
  logic [31:0] base_al;
  logic [31:0] nxt_jmp;

  assign trap_req = cap_exc | int_any;
  assign sel_pc   = stg_any ? cap_pc[32*int'(stg_idx) +: 32] : 32'd0;
  assign base_al  = {cap_base[31:2], 2'b00};

  always_comb begin
    nxt_code = '0;
    if (cap_exc) begin
      nxt_code[CODE_W-1:0] = cap_code;
    end else begin
      nxt_code[IDX_W-1:0]          = int_idx;
      nxt_code[MCAUSE_INT_BIT]     = 1'b1;
    end
  end

  // Only interrupts are vectored; exceptions always land on the base.
  assign nxt_jmp = (!cap_exc && cap_mode == VEC_VECTORED)
                 ? base_al + (32'(int_idx) << 2)
                 : base_al;

  trap_state_t      state;
  logic [CNT_W-1:0] hold_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      TRAP_EN     <= 1'b0;
      TRAP_PC     <= '0;
      TRAP_CODE   <= '0;
      TRAP_JMP_TO <= '0;
      TRAP_BUSY   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trap_req) begin
            TRAP_EN     <= 1'b1;
            TRAP_PC     <= sel_pc;
            TRAP_CODE   <= nxt_code;
            TRAP_JMP_TO <= nxt_jmp;
            TRAP_BUSY   <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (TRAP_ACK) begin
            TRAP_EN <= 1'b0;
            if (HOLDOFF == 0) begin
              TRAP_BUSY <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              hold_cnt <= CNT_W'(HOLDOFF);
              state    <= ST_HOLDOFF;
            end
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt <= CNT_W'(1)) begin
            TRAP_BUSY <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          TRAP_EN   <= 1'b0;
          TRAP_BUSY <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed scenarios plus randomized traffic checked every cycle against a
// behavioural model of the trap controller.
module tb_trap_ctrl;

  localparam int NS = 6;
  localparam int NI = 16;
  localparam int HO = 3;

  logic          CLK, RST_N, FLUSH, MMU_WAIT;
  logic [32*NS-1:0] STAGE_PC;
  logic [NS-1:0] STAGE_VALID;
  logic          EXC_EN;
  logic [4:0]    EXC_CODE;
  logic [NI-1:0] INT_PEND, INT_MASK;
  logic          INT_GLOBAL_EN;
  logic [1:0]    TRAP_VEC_MODE;
  logic [31:0]   TRAP_VEC_BASE;
  logic          TRAP_ACK;
  logic          TRAP_EN, TRAP_BUSY;
  logic [31:0]   TRAP_PC, TRAP_CODE, TRAP_JMP_TO;

  trap_ctrl #(.NUM_STAGES(NS), .NUM_INT(NI), .CODE_W(5), .HOLDOFF(HO)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .MMU_WAIT(MMU_WAIT),
    .STAGE_PC(STAGE_PC), .STAGE_VALID(STAGE_VALID), .EXC_EN(EXC_EN),
    .EXC_CODE(EXC_CODE), .INT_PEND(INT_PEND), .INT_MASK(INT_MASK),
    .INT_GLOBAL_EN(INT_GLOBAL_EN), .TRAP_VEC_MODE(TRAP_VEC_MODE),
    .TRAP_VEC_BASE(TRAP_VEC_BASE), .TRAP_ACK(TRAP_ACK), .TRAP_EN(TRAP_EN),
    .TRAP_PC(TRAP_PC), .TRAP_CODE(TRAP_CODE), .TRAP_JMP_TO(TRAP_JMP_TO),
    .TRAP_BUSY(TRAP_BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [32*NS-1:0] c_pc;
  logic [NS-1:0]    c_vld;
  logic             c_exc, c_ge;
  logic [4:0]       c_code;
  logic [NI-1:0]    c_pend, c_mask;
  logic [1:0]       c_mode;
  logic [31:0]      c_base;
  logic             m_en;
  logic [31:0]      m_pc, m_code, m_jmp;
  int               m_hold;

  task automatic mdl_reset();
    c_pc = '0; c_vld = '0; c_exc = 0; c_ge = 0; c_code = '0;
    c_pend = '0; c_mask = '0; c_mode = '0; c_base = '0;
    m_en = 0; m_pc = '0; m_code = '0; m_jmp = '0; m_hold = 0;
  endtask

  task automatic mdl_step();
    int idx;
    logic [31:0] pc;
    if (m_en) begin
      if (TRAP_ACK) begin
        m_en = 0;
        m_hold = HO;
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      idx = -1;
      for (int i = 0; i < NI; i++)
        if (c_ge && c_pend[i] && c_mask[i]) idx = i;
      pc = 0;
      for (int i = 0; i < NS; i++)
        if (c_vld[i]) pc = c_pc[32*i +: 32];
      if (c_exc || idx >= 0) begin
        m_en = 1;
        m_pc = pc;
        m_code = c_exc ? 32'(c_code) : (32'h8000_0000 | 32'(idx));
        m_jmp = (c_base & ~32'd3) + ((!c_exc && c_mode == 2'd1) ? 32'(idx * 4) : 32'd0);
      end
    end
    if (FLUSH) begin
      c_pc = '0; c_vld = '0; c_exc = 0; c_ge = 0; c_code = '0;
      c_pend = '0; c_mask = '0; c_mode = '0; c_base = '0;
    end else if (!MMU_WAIT) begin
      c_pc = STAGE_PC; c_vld = STAGE_VALID; c_exc = EXC_EN; c_code = EXC_CODE;
      c_pend = INT_PEND; c_mask = INT_MASK; c_ge = INT_GLOBAL_EN;
      c_mode = TRAP_VEC_MODE; c_base = TRAP_VEC_BASE;
    end
  endtask

  initial begin
    mdl_reset();
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) mdl_reset();
      else mdl_step();
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      chk("m_en",   32'(TRAP_EN),   32'(m_en));
      chk("m_pc",   TRAP_PC,        m_pc);
      chk("m_code", TRAP_CODE,      m_code);
      chk("m_jmp",  TRAP_JMP_TO,    m_jmp);
      chk("m_busy", 32'(TRAP_BUSY), 32'(m_en || m_hold > 0));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    FLUSH = 0; MMU_WAIT = 0; STAGE_PC = '0; STAGE_VALID = '0; EXC_EN = 0;
    EXC_CODE = '0; INT_PEND = '0; INT_MASK = '0; INT_GLOBAL_EN = 0;
    TRAP_VEC_MODE = 2'd0; TRAP_VEC_BASE = '0; TRAP_ACK = 0;
  endtask

  task automatic wait_en(input string tag, input logic val, input int budget);
    for (int i = 0; i < budget && TRAP_EN !== val; i++) step();
    chk(tag, 32'(TRAP_EN), 32'(val));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && TRAP_BUSY !== 1'b0; i++) step();
    chk(tag, 32'(TRAP_BUSY), 32'd0);
  endtask

  task automatic ack_pulse();
    TRAP_ACK = 1;
    step();
    TRAP_ACK = 0;
  endtask

  logic [31:0] s_pc, s_code, s_jmp;

  initial begin
    quiet();
    RST_N = 0;
    repeat (3) step();
    chk("rst_en",   32'(TRAP_EN), 0);
    chk("rst_pc",   TRAP_PC, 0);
    chk("rst_code", TRAP_CODE, 0);
    chk("rst_jmp",  TRAP_JMP_TO, 0);
    chk("rst_busy", 32'(TRAP_BUSY), 0);
    RST_N = 1;
    step();

    // Stage selection, exception never vectored, base low bits dropped.
    for (int i = 0; i < NS; i++) STAGE_PC[32*i +: 32] = 32'h100 * (i + 1);
    STAGE_PC[32*3 +: 32] = 32'h0000_1040;
    STAGE_PC[32*5 +: 32] = 32'hDEAD_0000;
    STAGE_VALID = 6'b001101;
    EXC_EN = 1; EXC_CODE = 5'd2;
    TRAP_VEC_BASE = 32'h8000_0001; TRAP_VEC_MODE = 2'd1;
    step();
    chk("lat_e0", 32'(TRAP_EN), 0);
    EXC_EN = 0;
    step();
    chk("lat_e1", 32'(TRAP_EN), 1);
    chk("t1_pc",   TRAP_PC, 32'h0000_1040);
    chk("t1_code", TRAP_CODE, 32'h0000_0002);
    chk("t1_jmp",  TRAP_JMP_TO, 32'h8000_0000);
    ack_pulse();
    chk("t1_ackfall", 32'(TRAP_EN), 0);
    wait_idle("t1_idle", 10);

    // Vectored interrupt: highest set line of 0x0880 is 11.
    INT_PEND = 16'h0880; INT_MASK = 16'hFFFF; INT_GLOBAL_EN = 1;
    TRAP_VEC_BASE = 32'h8000_0000;
    wait_en("t2_en", 1, 10);
    chk("t2_code", TRAP_CODE, 32'h8000_000B);
    chk("t2_jmp",  TRAP_JMP_TO, 32'h8000_002C);
    INT_PEND = '0;
    ack_pulse();
    wait_idle("t2_idle", 10);

    // Exception beats interrupt; interrupt follows after hold-off.
    EXC_EN = 1; EXC_CODE = 5'd5; INT_PEND = 16'h0008;
    wait_en("t3_en", 1, 10);
    chk("t3_code", TRAP_CODE, 32'h0000_0005);
    EXC_EN = 0;
    ack_pulse();
    wait_en("t3_en2", 1, 12);
    chk("t3_code2", TRAP_CODE, 32'h8000_0003);
    INT_PEND = '0;
    ack_pulse();
    wait_idle("t3_idle", 10);

    // Masked: per-line mask, then global enable.
    INT_PEND = 16'h0080; INT_MASK = 16'h0000;
    for (int i = 0; i < 20; i++) begin step(); chk("mask_line", 32'(TRAP_EN), 0); end
    INT_MASK = 16'hFFFF; INT_GLOBAL_EN = 0;
    for (int i = 0; i < 20; i++) begin step(); chk("mask_glob", 32'(TRAP_EN), 0); end
    INT_PEND = '0;

    // Held request stays frozen through stalls, flushes and input churn.
    EXC_EN = 1; EXC_CODE = 5'd7;
    wait_en("t5_en", 1, 10);
    EXC_EN = 0;
    s_pc = TRAP_PC; s_code = TRAP_CODE; s_jmp = TRAP_JMP_TO;
    chk("t5_code", TRAP_CODE, 32'h0000_0007);
    for (int i = 0; i < 5; i++) begin
      MMU_WAIT = 1'($urandom); FLUSH = 1'($urandom); INT_PEND = 16'($urandom);
      step();
      chk("hold_en",   32'(TRAP_EN), 1);
      chk("hold_pc",   TRAP_PC, s_pc);
      chk("hold_code", TRAP_CODE, s_code);
      chk("hold_jmp",  TRAP_JMP_TO, s_jmp);
    end
    MMU_WAIT = 0; FLUSH = 0; INT_PEND = '0;
    ack_pulse();
    chk("t5_ackfall", 32'(TRAP_EN), 0);
    chk("t5_busy0", 32'(TRAP_BUSY), 1);
    for (int i = 1; i < HO; i++) begin step(); chk("t5_busy", 32'(TRAP_BUSY), 1); end
    step();
    chk("t5_busy_end", 32'(TRAP_BUSY), 0);

    // Async reset mid-issue drops the trap without an ACK.
    EXC_EN = 1; EXC_CODE = 5'd9;
    wait_en("t6_en", 1, 10);
    #1 RST_N = 0;
    #1;
    chk("arst_en",   32'(TRAP_EN), 0);
    chk("arst_pc",   TRAP_PC, 0);
    chk("arst_code", TRAP_CODE, 0);
    chk("arst_jmp",  TRAP_JMP_TO, 0);
    chk("arst_busy", 32'(TRAP_BUSY), 0);
    RST_N = 1;
    step();
    chk("arst_nocap", 32'(TRAP_EN), 0);
    step();
    chk("arst_recap", 32'(TRAP_EN), 1);
    EXC_EN = 0;
    ack_pulse();
    wait_idle("t6_idle", 10);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      FLUSH         = ($urandom_range(0, 7) == 0);
      MMU_WAIT      = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NS; i++) STAGE_PC[32*i +: 32] = $urandom;
      STAGE_VALID   = 6'($urandom);
      EXC_EN        = ($urandom_range(0, 7) == 0);
      EXC_CODE      = 5'($urandom);
      INT_PEND      = 16'($urandom & $urandom & $urandom);
      INT_MASK      = 16'($urandom);
      INT_GLOBAL_EN = ($urandom_range(0, 3) != 0);
      TRAP_VEC_MODE = 2'($urandom);
      TRAP_VEC_BASE = $urandom;
      TRAP_ACK      = ($urandom_range(0, 2) == 0);
      step();
    end

    quiet();
    TRAP_ACK = 1;
    repeat (10) step();
    TRAP_ACK = 0;
    wait_idle("final_idle", 10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
